cmos_upload_reader: RTL
=======================

Name: cmos_upload_reader

Overview:
- Serves HPS upload (core→HPS) requests for the Williams CMOS NVRAM (1024×4, high scores and settings).
- It is the read-back counterpart of the ROM/NVRAM download write path into williams2.
- Sits between hps_io's ioctl upload signals and a secondary CMOS RAM port that it shares with the 6809 through a request/grant handshake.
- Also tracks CPU writes to CMOS and raises an autosave request once writes have settled.

Parameters:
- ADDR_W, 10, CMOS address width; the last address is 2^ADDR_W-1.
- DATA_W, 4, CMOS data width.
- PAD, 4'hF, constant placed in the upper byte bits [7:DATA_W] of ioctl_din.
- GNT_TIMEOUT, 255, maximum cycles to wait for cmos_gnt before aborting the read.
- SETTLE, 24'd6000000, write-quiet cycles (0.5 s at 12 MHz) before autosave_req is raised.

Ports:
- clock_12 in 1 system clock.
- reset_n in 1 asynchronous active-low reset.
- ioctl_upload in 1 HPS upload session active.
- ioctl_rd in 1 one-cycle read strobe; ioctl_addr is valid in the same cycle.
- ioctl_addr in 25 byte address; only [ADDR_W-1:0] is used.
- ioctl_din out 8 read data {PAD, nibble}.
- ioctl_wait out 1 high while a read is pending.
- cmos_req out 1 request for the CMOS secondary port.
- cmos_gnt in 1 grant from the CPU-side arbiter.
- cmos_addr out ADDR_W address presented to the CMOS secondary port.
- cmos_q in DATA_W CMOS read data; valid 1 cycle after a granted cycle.
- cpu_cmos_we in 1 CPU CMOS write strobe (one cycle).
- dirty out 1 CMOS has changed since the last complete upload.
- autosave_req out 1 one-cycle pulse.
- rd_timeout out 1 sticky error flag.

Behaviour:
- Reset (asynchronous, reset_n=0) clears: ioctl_din=8'h00, ioctl_wait=0, cmos_req=0, cmos_addr=0, dirty=0, autosave_req=0, rd_timeout=0, FSM=IDLE, settle counter=0.
- FSM states: IDLE, REQ, READ, DONE.
- IDLE:
  - ioctl_rd & ioctl_upload → latch the address into cmos_addr, assert cmos_req=1 and ioctl_wait=1, go to REQ.
  - ioctl_rd without ioctl_upload is ignored.
- REQ:
  - cmos_gnt=1 → go to READ.
  - Otherwise the timeout counter increments.
  - Counter reaches GNT_TIMEOUT → ioctl_din={PAD,4'hF}, set rd_timeout, go to DONE.
- READ (one cycle after the grant):
  - Capture ioctl_din={PAD,cmos_q}.
  - Drop cmos_req, go to DONE.
- DONE: drop ioctl_wait, go to IDLE.
  - Best-case latency from ioctl_rd to ioctl_wait falling is 4 cycles (gnt tied high).
- cmos_req stays high continuously from the REQ entry to the READ exit. cmos_addr is stable while cmos_req=1.
- ioctl_rd while ioctl_wait=1 is ignored. The HPS side honours ioctl_wait.
- ioctl_upload falling mid-read aborts the read:
  - cmos_req drops on the next cycle and the FSM goes to DONE.
  - ioctl_din is left unchanged.
- ioctl_din holds its value until the next completed read.
- Dirty tracking:
  - cpu_cmos_we sets dirty and resets the settle counter.
  - A completed read of address 2^ADDR_W-1 in an active upload clears dirty.
  - If that completion coincides with cpu_cmos_we in the same cycle, dirty stays 1 (set wins).
- Settle counter:
  - Counts only while dirty=1 and ioctl_upload=0. It saturates at SETTLE.
  - Reaching SETTLE produces exactly one autosave_req pulse per dirty episode.
  - Re-arming requires a new cpu_cmos_we.
- rd_timeout is cleared only by reset.

Test Plan:
- gnt tied high, CMOS[0x005]=4'hA, upload with rd at addr 5 → cmos_req high for 2 cycles; ioctl_din=8'hFA; ioctl_wait falls 4 cycles after rd.
- gnt delayed 10 cycles, CMOS[0x3FF]=4'h3 → cmos_addr=10'h3FF is stable throughout; ioctl_din=8'hF3; ioctl_wait is high for 13 cycles.
- gnt never asserted → after 255 REQ cycles, ioctl_din=8'hFF, rd_timeout=1, cmos_req=0, FSM back in IDLE.
- cpu_cmos_we once, SETTLE overridden to 100, no upload → dirty=1; autosave_req pulses once exactly 100 cycles later; no further pulse.
- Write at cycle 50, then full 1024-address upload → dirty clears on the 0x3FF completion. Repeat with cpu_cmos_we in the completion cycle → dirty stays 1.
- Assert reset_n low mid-REQ → all outputs return to reset values immediately without a clock edge; after release, a new rd is serviced normally.

Source files
------------

// File: rtl/cmos_upload_reader.sv
// cmos_upload_reader: serves HPS upload reads of the 1024x4 CMOS NVRAM through a
// shared secondary RAM port (request/grant), and tracks CPU writes to raise a
// one-shot autosave request once the CMOS contents have been quiet long enough.
module cmos_upload_reader #(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       DATA_W      = 4,
  parameter logic [7-DATA_W:0] PAD         = 4'hF,
  parameter int unsigned       GNT_TIMEOUT = 255,
  parameter logic [23:0]       SETTLE      = 24'd6000000
) (
  input  logic              clock_12,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              cmos_req,
  input  logic              cmos_gnt,
  output logic [ADDR_W-1:0] cmos_addr,
  input  logic [DATA_W-1:0] cmos_q,
  input  logic              cpu_cmos_we,
  output logic              dirty,
  output logic              autosave_req,
  output logic              rd_timeout
);

  localparam int unsigned       TW        = $clog2(GNT_TIMEOUT + 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(GNT_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic              dirty_q, dirty_d;
  logic [23:0]       settle_q, settle_d;
  logic              autosave_q, autosave_d;
  logic              read_done;

  // Only the low address bits select a CMOS nibble; the rest of the byte address is ignored.
  logic addr_hi_unused;
  assign addr_hi_unused = ^ioctl_addr[24:ADDR_W];

  // Read sequencer: accept a read, win the shared port, capture the nibble, release the HPS.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wait_d     = wait_q;
    req_d      = req_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    read_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_rd && ioctl_upload) begin
          addr_d  = ioctl_addr[ADDR_W-1:0];
          req_d   = 1'b1;
          wait_d  = 1'b1;
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!ioctl_upload) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cmos_gnt) begin
          state_d = ST_READ;
        end else if (tmo_q == TMO_LAST) begin
          din_d      = {PAD, {DATA_W{1'b1}}};
          tmo_flag_d = 1'b1;
          req_d      = 1'b0;
          state_d    = ST_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_READ: begin
        req_d   = 1'b0;
        state_d = ST_DONE;
        if (ioctl_upload) begin
          din_d     = {PAD, cmos_q};
          read_done = 1'b1;
        end
      end
      ST_DONE: begin
        wait_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dirty tracking and write-settle timer; a CPU write always wins over the upload clear.
  always_comb begin
    dirty_d    = dirty_q;
    settle_d   = settle_q;
    autosave_d = 1'b0;
    if (cpu_cmos_we) begin
      dirty_d  = 1'b1;
      settle_d = '0;
    end else if (read_done && (addr_q == LAST_ADDR)) begin
      dirty_d  = 1'b0;
      settle_d = '0;
    end else if (dirty_q && !ioctl_upload && (settle_q != SETTLE)) begin
      settle_d = settle_q + 24'd1;
      if (settle_q == (SETTLE - 24'd1)) begin
        autosave_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      din_q      <= '0;
      wait_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      dirty_q    <= 1'b0;
      settle_q   <= '0;
      autosave_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
      dirty_q    <= dirty_d;
      settle_q   <= settle_d;
      autosave_q <= autosave_d;
    end
  end

  assign ioctl_din    = din_q;
  assign ioctl_wait   = wait_q;
  assign cmos_req     = req_q;
  assign cmos_addr    = addr_q;
  assign dirty        = dirty_q;
  assign autosave_req = autosave_q;
  assign rd_timeout   = tmo_flag_q;

endmodule
